// File: rtl/mbus_master_wake_ctrl.sv
// Master-side wake controller for the MBus ring.
// Qualifies a member bus request (DIN low while CIN idles high) or a local
// WAKEUP_REQ, drives a glitch-free wake-clock train onto the ring, then hands
// off to the master bus controller through a START_REQ/START_ACK handshake.
module mbus_master_wake_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    parameter int HALF_PERIOD = 8,
    parameter int NUM_PULSES  = 3,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       DIN,
    input  logic       CIN,
    input  logic       WAKEUP_REQ,
    input  logic       BUS_BUSY,
    input  logic       START_ACK,
    output logic       WAKE_CLK_EN,
    output logic       WAKE_CLK_OUT,
    output logic       START_REQ,
    output logic [1:0] WAKE_SRC,
    output logic       WAKE_DONE,
    output logic       WAKE_ERR,
    output logic       BUSY
);

    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int HW = $clog2(HALF_PERIOD + 1);
    localparam int PW = $clog2(NUM_PULSES + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        QUAL   = 3'd1,
        CLK_LO = 3'd2,
        CLK_HI = 3'd3,
        REQ    = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t          state, state_n;
    logic [SYNC_STAGES-1:0] din_sync, cin_sync;
    logic            din_s, cin_s;
    logic [DW-1:0]   dcnt, dcnt_n;
    logic [HW-1:0]   hcnt, hcnt_n;
    logic [PW-1:0]   pcnt, pcnt_n, pcnt_inc;
    logic [TW-1:0]   tcnt, tcnt_n, tcnt_inc;
    logic [1:0]      src_n;
    logic            rearm, rearm_n;
    logic            err_n;

    assign din_s    = din_sync[SYNC_STAGES-1];
    assign cin_s    = cin_sync[SYNC_STAGES-1];
    assign pcnt_inc = pcnt + PW'(1);
    assign tcnt_inc = tcnt + TW'(1);

    // Ring inputs are asynchronous; flops idle at the bus-high level.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            din_sync <= '1;
            cin_sync <= '1;
        end else begin
            din_sync <= {din_sync[SYNC_STAGES-2:0], DIN};
            cin_sync <= {cin_sync[SYNC_STAGES-2:0], CIN};
        end
    end

    // State and counter registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            dcnt  <= '0;
            hcnt  <= '0;
            pcnt  <= '0;
            tcnt  <= '0;
            rearm <= 1'b1;
        end else begin
            state <= state_n;
            dcnt  <= dcnt_n;
            hcnt  <= hcnt_n;
            pcnt  <= pcnt_n;
            tcnt  <= tcnt_n;
            rearm <= rearm_n;
        end
    end

    // Next-state, counter and wake-source decisions.
    always_comb begin
        state_n = state;
        dcnt_n  = dcnt;
        hcnt_n  = hcnt;
        pcnt_n  = pcnt;
        tcnt_n  = tcnt;
        src_n   = WAKE_SRC;
        rearm_n = rearm;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                // A member must release DIN before it can request again.
                if (din_s) rearm_n = 1'b1;
                if (!BUS_BUSY) begin
                    if (WAKEUP_REQ) begin
                        state_n = CLK_LO;
                        src_n   = 2'b10;
                    end else if (rearm && !din_s && cin_s) begin
                        state_n = QUAL;
                        dcnt_n  = '0;
                    end
                end
            end
            QUAL: begin
                if (din_s || BUS_BUSY) begin
                    state_n = IDLE;
                end else if (dcnt == DW'(DEBOUNCE - 1)) begin
                    state_n = CLK_LO;
                    src_n   = {WAKEUP_REQ, 1'b1};
                end else begin
                    dcnt_n = dcnt + DW'(1);
                end
            end
            CLK_LO: begin
                if (hcnt == HW'(HALF_PERIOD - 1)) begin
                    state_n = CLK_HI;
                    hcnt_n  = '0;
                end else begin
                    hcnt_n = hcnt + HW'(1);
                end
            end
            CLK_HI: begin
                if (hcnt == HW'(HALF_PERIOD - 1)) begin
                    hcnt_n = '0;
                    if (pcnt_inc == PW'(NUM_PULSES)) begin
                        state_n = REQ;
                        pcnt_n  = '0;
                        tcnt_n  = '0;
                    end else begin
                        state_n = CLK_LO;
                        pcnt_n  = pcnt_inc;
                    end
                end else begin
                    hcnt_n = hcnt + HW'(1);
                end
            end
            REQ: begin
                // ACK on the timeout cycle still counts as success.
                if (START_ACK) begin
                    state_n = DONE;
                    tcnt_n  = '0;
                end else if (tcnt_inc == TW'(ACK_TIMEOUT)) begin
                    state_n = IDLE;
                    tcnt_n  = '0;
                    err_n   = 1'b1;
                end else begin
                    tcnt_n = tcnt_inc;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // Every train starts from fresh counters and disarms member requests.
        if (state_n == CLK_LO && (state == IDLE || state == QUAL)) begin
            hcnt_n  = '0;
            pcnt_n  = '0;
            rearm_n = 1'b0;
        end
    end

    // Outputs registered from the next state so the ring sees clean edges.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            WAKE_CLK_EN  <= 1'b0;
            WAKE_CLK_OUT <= 1'b1;
            START_REQ    <= 1'b0;
            WAKE_SRC     <= 2'b00;
            WAKE_DONE    <= 1'b0;
            WAKE_ERR     <= 1'b0;
            BUSY         <= 1'b0;
        end else begin
            WAKE_CLK_EN  <= (state_n == CLK_LO) || (state_n == CLK_HI);
            WAKE_CLK_OUT <= (state_n != CLK_LO);
            START_REQ    <= (state_n == REQ);
            WAKE_SRC     <= src_n;
            WAKE_DONE    <= (state_n == DONE);
            WAKE_ERR     <= err_n;
            BUSY         <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_mbus_master_wake_ctrl.sv
// Bench for mbus_master_wake_ctrl: directed scenarios with literal timing
// expectations plus randomized traffic, all checked every cycle against a
// phase/elapsed-time model of the wake sequence.
module tb_mbus_master_wake_ctrl;

    localparam int SS = 2, DB = 4, HP = 8, NP = 3, AT = 255;
    localparam int P_IDLE = 0, P_QUAL = 1, P_TRAIN = 2, P_REQ = 3, P_DONE = 4;
    localparam int S_EN = 0, S_OUT = 1, S_REQ = 2, S_DONE = 3, S_ERR = 4, S_BUSY = 5;

    logic clk = 1'b0, rst = 1'b1, din = 1'b1, cin = 1'b1;
    logic wreq = 1'b0, bb = 1'b0, ack = 1'b0;
    logic en, out, sreq, done, err, busy;
    logic [1:0] src;

    int checks = 0, failures = 0;

    mbus_master_wake_ctrl #(.SYNC_STAGES(SS), .DEBOUNCE(DB), .HALF_PERIOD(HP),
                            .NUM_PULSES(NP), .ACK_TIMEOUT(AT)) dut (
        .CLK(clk), .RESET(rst), .DIN(din), .CIN(cin), .WAKEUP_REQ(wreq),
        .BUS_BUSY(bb), .START_ACK(ack), .WAKE_CLK_EN(en), .WAKE_CLK_OUT(out),
        .START_REQ(sreq), .WAKE_SRC(src), .WAKE_DONE(done), .WAKE_ERR(err),
        .BUSY(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Model: coarse phase plus elapsed cycles inside that phase.
    bit [SS-1:0] m_din = '1, m_cin = '1;
    int m_ph = P_IDLE, m_q = 0, m_k = 0;
    bit m_rearm = 1'b1, m_err = 1'b0;
    bit [1:0] m_src = 2'b00;

    task automatic start_train(input bit [1:0] s);
        m_ph = P_TRAIN; m_k = 0; m_src = s; m_rearm = 1'b0;
    endtask

    task automatic model_step();
        bit ds, cs;
        if (rst) begin
            m_din = '1; m_cin = '1; m_ph = P_IDLE; m_q = 0; m_k = 0;
            m_rearm = 1'b1; m_err = 1'b0; m_src = 2'b00;
            return;
        end
        ds = m_din[SS-1];
        cs = m_cin[SS-1];
        m_err = 1'b0;
        case (m_ph)
            P_IDLE: begin
                if (ds) m_rearm = 1'b1;
                if (!bb) begin
                    if (wreq) start_train(2'b10);
                    else if (m_rearm && !ds && cs) begin m_ph = P_QUAL; m_q = 0; end
                end
            end
            P_QUAL: begin
                if (ds || bb) m_ph = P_IDLE;
                else begin
                    m_q++;
                    if (m_q == DB) start_train({wreq, 1'b1});
                end
            end
            P_TRAIN: begin
                m_k++;
                if (m_k == 2 * HP * NP) begin m_ph = P_REQ; m_k = 0; end
            end
            P_REQ: begin
                if (ack) m_ph = P_DONE;
                else begin
                    m_k++;
                    if (m_k == AT) begin m_ph = P_IDLE; m_err = 1'b1; end
                end
            end
            default: m_ph = P_IDLE;
        endcase
        m_din = {m_din[SS-2:0], din};
        m_cin = {m_cin[SS-2:0], cin};
    endtask

    function automatic logic [7:0] model_out();
        logic lo;
        lo = (m_ph == P_TRAIN) && ((m_k / HP) % 2 == 0);
        return {m_ph == P_TRAIN, !lo, m_ph == P_REQ, m_src,
                m_ph == P_DONE, m_err, m_ph != P_IDLE};
    endfunction

    function automatic logic dsig(input int s);
        case (s)
            S_EN:   return en;
            S_OUT:  return out;
            S_REQ:  return sreq;
            S_DONE: return done;
            S_ERR:  return err;
            default: return busy;
        endcase
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    // One clock: model advances on the edge, outputs compared on the far edge.
    task automatic tick();
        logic [7:0] got, exp;
        @(posedge clk);
        model_step();
        @(negedge clk);
        got = {en, out, sreq, src, done, err, busy};
        exp = model_out();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL cycle_cmp t=%0t got=%b exp=%b", $time, got, exp);
        end
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_sig(input string name, input int s, input int max, output int n);
        n = 0;
        while (dsig(s) !== 1'b1 && n < max) begin tick(); n++; end
        if (n >= max) chk({name, "_timeout"}, n, -1);
    endtask

    task automatic finish_ack();
        int n;
        wait_sig("req_wait", S_REQ, 200, n);
        ack = 1'b1; tick(); ack = 1'b0; tick();
    endtask

    initial begin
        int n, m, first_hi;
        bit seen;
        int ack_mode;

        ticks(3);
        chk("reset_outputs", {en, out, sreq, src, done, err, busy}, 8'b0100_0000);
        rst = 1'b0;
        ticks(3);

        // DIN glitch shorter than the debounce window.
        din = 1'b0; ticks(3); din = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin tick(); if (en) seen = 1'b1; end
        chk("glitch_no_en", seen, 0);
        chk("glitch_src", src, 0);
        chk("glitch_busy", busy, 0);

        // Member wake with default timing.
        din = 1'b0;
        wait_sig("mem_en", S_EN, 30, n);
        chk("mem_en_latency", n, 7);
        chk("mem_first_low", out, 0);
        m = 0; first_hi = -1;
        while (en && m < 200) begin
            tick(); m++;
            if (out && first_hi < 0) first_hi = m;
        end
        chk("mem_first_low_len", first_hi, 8);
        chk("mem_train_len", m, 48);
        chk("mem_req_up", sreq, 1);
        ticks(2); ack = 1'b1; tick(); ack = 1'b0;
        chk("mem_done", done, 1);
        chk("mem_req_drop", sreq, 0);
        chk("mem_src", src, 1);
        tick();
        chk("mem_done_pulse", done, 0);
        chk("mem_idle", busy, 0);
        din = 1'b1; ticks(4);

        // Local request arriving during qualification.
        din = 1'b0; ticks(4); wreq = 1'b1;
        wait_sig("qual_local_en", S_EN, 20, n);
        chk("qual_local_src", src, 3);
        wreq = 1'b0; finish_ack(); din = 1'b1; ticks(4);

        // Local request and member request seen together in IDLE.
        din = 1'b0; ticks(2); wreq = 1'b1; tick();
        chk("both_idle_en", en, 1);
        chk("both_idle_src", src, 2);
        wreq = 1'b0; finish_ack(); din = 1'b1; ticks(4);

        // ACK timeout, then no retrigger while DIN stays low.
        din = 1'b0;
        wait_sig("to_req", S_REQ, 200, n);
        m = 0;
        while (sreq && m < 400) begin tick(); m++; end
        chk("to_req_len", m, 255);
        chk("to_err", err, 1);
        chk("to_busy", busy, 0);
        tick();
        chk("to_err_pulse", err, 0);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin tick(); if (busy) seen = 1'b1; end
        chk("to_no_retrigger", seen, 0);
        din = 1'b1; ticks(4); din = 1'b0;
        wait_sig("rearm_en", S_EN, 30, n);
        chk("rearm_latency", n, 7);
        finish_ack(); din = 1'b1; ticks(4);

        // BUS_BUSY blocks a member request until released.
        bb = 1'b1; din = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin tick(); if (busy) seen = 1'b1; end
        chk("bb_block", seen, 0);
        bb = 1'b0;
        wait_sig("bb_release_en", S_EN, 30, n);
        chk("bb_release_latency", n, 5);

        // Reset in the low phase of pulse 2, then a fresh full train.
        ticks(18);
        chk("mid_pulse2_low", out, 0);
        rst = 1'b1; #1;
        chk("rst_en_async", en, 0);
        chk("rst_out_async", out, 1);
        chk("rst_busy_async", busy, 0);
        tick(); rst = 1'b0;
        wait_sig("post_rst_en", S_EN, 30, n);
        chk("post_rst_latency", n, 7);
        m = 0;
        while (en && m < 200) begin tick(); m++; end
        chk("post_rst_train_len", m, 48);
        finish_ack(); din = 1'b1; ticks(4);

        // Randomized traffic checked against the model every cycle.
        ack_mode = 1;
        for (int i = 0; i < 6000; i++) begin
            tick();
            if (i % 512 == 0) ack_mode = $urandom_range(0, 2);
            if ($urandom_range(0, 15) == 0) din = ~din;
            cin = ($urandom_range(0, 31) != 0);
            if ($urandom_range(0, 63) == 0) wreq = ~wreq;
            if ($urandom_range(0, 39) == 0) bb = ~bb;
            ack = (ack_mode != 0) && ($urandom_range(0, 5) == 0);
            rst = ($urandom_range(0, 1999) == 0);
        end
        rst = 1'b0; ticks(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
